// File: rtl/processador_param.sv
// ---------------------------------------------------------------------------
// processador_param
// Parametrised multicycle 16-bit-instruction core. Each instruction walks
// FETCH -> DECODE -> EXEC -> WB; FETCH waits on a request/valid instruction
// memory handshake. Supports ALU ops, shifts, BEQ, JMP, HALT, a retired
// instruction counter and a combinational debug register read port.
//
// Optional feature (compile-time macro):
//   PROC_MUL_EN  opcode 11 becomes MUL (low DATA_W bits of unsigned product);
//                when undefined, opcode 11 is a NOP and no multiplier exists.
//
// Parameters:
//   DATA_W  datapath / register width (>= 8)
//   ADDR_W  PC / instruction address width (<= 12)
//   NREG    implemented registers (2..16); other indices read 0, ignore writes
//
// Ports:
//   CLOCK_50       clock, rising edge
//   reset          asynchronous active-high reset
//   imem_req       fetch request, high for the whole FETCH state
//   imem_addr      fetch address (always the PC)
//   imem_valid     instruction word valid (sampled only in FETCH)
//   imem_rdata     instruction word
//   pc_o           current PC
//   halted         core has executed HALT
//   retired_count  completed instructions, wraps modulo 2^32
//   dbg_sel        debug register index
//   dbg_data       combinational read of R[dbg_sel]
// ---------------------------------------------------------------------------
module processador_param #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned NREG   = 16
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_valid,
  input  logic [15:0]       imem_rdata,
  output logic [ADDR_W-1:0] pc_o,
  output logic              halted,
  output logic [31:0]       retired_count,
  input  logic [3:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int unsigned IDX_W = (NREG > 1) ? $clog2(NREG) : 1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_ADDI = 4'd6;
  localparam logic [3:0] OP_SHL  = 4'd7;
  localparam logic [3:0] OP_SHR  = 4'd8;
  localparam logic [3:0] OP_BEQ  = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd11;
  localparam logic [3:0] OP_JMP  = 4'd12;
  localparam logic [3:0] OP_HALT = 4'd15;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_WB,
    ST_HALT
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   pc;
  logic [15:0]         ir;
  logic [DATA_W-1:0]   opa;
  logic [DATA_W-1:0]   opb;
  logic [DATA_W-1:0]   opc;
  logic [DATA_W-1:0]   result;
  logic [ADDR_W-1:0]   next_pc;
  logic                wen;
  logic [DATA_W-1:0]   regs [NREG];

  logic [3:0]          op;
  logic [3:0]          imm4;
  logic [DATA_W-1:0]   alu_c;
  logic [ADDR_W-1:0]   npc_c;
  logic                wen_c;
  logic [IDX_W-1:0]    wr_idx_c;
  logic                wr_ok_c;

  assign op        = ir[15:12];
  assign imm4      = ir[7:4];
  assign imem_addr = pc;
  assign pc_o      = pc;

  // Register read with R0 and unimplemented indices forced to zero.
  function automatic logic [DATA_W-1:0] reg_read(input logic [3:0] idx);
    if (idx == 4'd0 || 32'(idx) >= NREG) begin
      return '0;
    end
    return regs[idx[IDX_W-1:0]];
  endfunction

  // Debug port: live view of the register file.
  always_comb begin
    dbg_data = reg_read(dbg_sel);
  end

  // Destination decode for writeback; R0 and out-of-range targets are dropped.
  always_comb begin
    wr_idx_c = ir[8 +: IDX_W];
    wr_ok_c  = (ir[11:8] != 4'd0) && (32'(ir[11:8]) < NREG);
  end

  // EXEC datapath: ALU result, write enable and next PC from operand registers.
  always_comb begin
    alu_c = '0;
    wen_c = 1'b0;
    npc_c = pc + ADDR_W'(1);
    case (op)
      OP_ADD: begin
        alu_c = opa + opb;
        wen_c = 1'b1;
      end
      OP_SUB: begin
        alu_c = opa - opb;
        wen_c = 1'b1;
      end
      OP_AND: begin
        alu_c = opa & opb;
        wen_c = 1'b1;
      end
      OP_OR: begin
        alu_c = opa | opb;
        wen_c = 1'b1;
      end
      OP_XOR: begin
        alu_c = opa ^ opb;
        wen_c = 1'b1;
      end
      OP_SLT: begin
        alu_c = ($signed(opa) < $signed(opb)) ? DATA_W'(1) : '0;
        wen_c = 1'b1;
      end
      OP_ADDI: begin
        alu_c = opb + DATA_W'(imm4);
        wen_c = 1'b1;
      end
      OP_SHL: begin
        // Shift amounts reaching the datapath width flush to zero.
        alu_c = (32'(imm4) >= DATA_W) ? '0 : (opb << imm4);
        wen_c = 1'b1;
      end
      OP_SHR: begin
        alu_c = (32'(imm4) >= DATA_W) ? '0 : (opb >> imm4);
        wen_c = 1'b1;
      end
      OP_BEQ: begin
        // Offset is a signed 4-bit displacement relative to PC+1.
        if (opc == opb) begin
          npc_c = pc + ADDR_W'(1) + ADDR_W'($signed(imm4));
        end
      end
`ifdef PROC_MUL_EN
      OP_MUL: begin
        alu_c = opa * opb;
        wen_c = 1'b1;
      end
`endif
      OP_JMP: begin
        npc_c = ir[ADDR_W-1:0];
      end
      default: begin
        alu_c = '0;
      end
    endcase
  end

  // Control FSM, operand/result registers, register file and counters.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state         <= ST_FETCH;
      pc            <= '0;
      ir            <= '0;
      opa           <= '0;
      opb           <= '0;
      opc           <= '0;
      result        <= '0;
      next_pc       <= '0;
      wen           <= 1'b0;
      imem_req      <= 1'b1;
      halted        <= 1'b0;
      retired_count <= '0;
      regs          <= '{default: '0};
    end else begin
      case (state)
        ST_FETCH: begin
          if (imem_valid) begin
            ir       <= imem_rdata;
            imem_req <= 1'b0;
            state    <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          opa <= reg_read(ir[7:4]);
          opb <= reg_read(ir[3:0]);
          opc <= reg_read(ir[11:8]);
          if (op == OP_HALT) begin
            // HALT retires on entry; PC stays on the HALT instruction.
            halted        <= 1'b1;
            retired_count <= retired_count + 32'd1;
            state         <= ST_HALT;
          end else begin
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          result  <= alu_c;
          next_pc <= npc_c;
          wen     <= wen_c;
          state   <= ST_WB;
        end
        ST_WB: begin
          if (wen && wr_ok_c) begin
            regs[wr_idx_c] <= result;
          end
          pc            <= next_pc;
          retired_count <= retired_count + 32'd1;
          imem_req      <= 1'b1;
          state         <= ST_FETCH;
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        default: begin
          state    <= ST_FETCH;
          imem_req <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_processador_param.sv
// ---------------------------------------------------------------------------
// tb_processador_param
// Drives processador_param as an instruction memory with random wait states
// and random junk on the handshake outside FETCH, and compares the core
// against an instruction-level interpreter of the ISA.
// ---------------------------------------------------------------------------
module tb_processador_param;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 12;
  localparam int unsigned NR = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_valid;
  logic [15:0]   imem_rdata;
  logic [AW-1:0] pc_o;
  logic          halted;
  logic [31:0]   retired_count;
  logic [3:0]    dbg_sel;
  logic [DW-1:0] dbg_data;

  processador_param #(.DATA_W(DW), .ADDR_W(AW), .NREG(NR)) dut (
    .CLOCK_50      (clk),
    .reset         (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_valid    (imem_valid),
    .imem_rdata    (imem_rdata),
    .pc_o          (pc_o),
    .halted        (halted),
    .retired_count (retired_count),
    .dbg_sel       (dbg_sel),
    .dbg_data      (dbg_data)
  );

  always #5 clk = ~clk;

  int          n_checks;
  int          n_errors;
  int          cycles;
  int          exp_cyc;
  logic [15:0] prog [4096];

  // ISA-level reference state.
  int          mreg [16];
  int          mpc;
  logic [31:0] mret;
  bit          mhalt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cycles++;
  endtask

  task automatic drive_junk();
    imem_valid = 1'($urandom_range(0, 1));
    imem_rdata = 16'($urandom);
  endtask

  task automatic clear_prog();
    foreach (prog[i]) prog[i] = 16'hA000;
  endtask

  task automatic read_dbg(input int r, output logic [31:0] v);
    dbg_sel = 4'(r);
    #1;
    v = 32'(dbg_data);
  endtask

  // Executes one instruction on the reference machine.
  task automatic model_exec(input logic [15:0] ins);
    int op, rc, ra, rb, a, b, c, res, soff, nxt;
    bit wr;
    op  = int'(ins[15:12]);
    rc  = int'(ins[11:8]);
    ra  = int'(ins[7:4]);
    rb  = int'(ins[3:0]);
    a   = mreg[ra];
    b   = mreg[rb];
    c   = mreg[rc];
    nxt = (mpc + 1) % 4096;
    wr  = 1'b1;
    res = 0;
    case (op)
      0: res = (a + b) % 65536;
      1: res = (a - b + 65536) % 65536;
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: res = (((a >= 32768) ? a - 65536 : a) < ((b >= 32768) ? b - 65536 : b)) ? 1 : 0;
      6: res = (b + ra) % 65536;
      7: res = int'((longint'(b) * (longint'(1) << ra)) % 65536);
      8: res = b / (1 << ra);
      9: begin
        wr = 1'b0;
        if (c == b) begin
          soff = (ra >= 8) ? ra - 16 : ra;
          nxt  = (mpc + 1 + soff + 4096) % 4096;
        end
      end
`ifdef PROC_MUL_EN
      11: res = int'((longint'(a) * longint'(b)) % 65536);
`endif
      12: begin
        wr  = 1'b0;
        nxt = int'(ins[11:0]);
      end
      15: begin
        wr    = 1'b0;
        mhalt = 1'b1;
        nxt   = mpc;
      end
      default: wr = 1'b0;
    endcase
    if (wr && rc != 0) mreg[rc] = res;
    mpc  = nxt;
    mret = mret + 32'd1;
  endtask

  task automatic do_reset();
    imem_valid = 1'b0;
    imem_rdata = 16'h0000;
    dbg_sel    = 4'd0;
    rst        = 1'b1;
    step();
    step();
    check("rst_pc", 32'(pc_o), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_retired", retired_count, 32'd0);
    rst     = 1'b0;
    cycles  = 0;
    exp_cyc = 0;
    mpc     = 0;
    mret    = 32'd0;
    mhalt   = 1'b0;
    foreach (mreg[i]) mreg[i] = 0;
  endtask

  // Serves instruction fetches from prog[] and checks each retirement.
  task automatic run_prog(input int max_instr, input int wmin, input int wmax);
    int          w, r;
    logic [15:0] ins;
    logic [31:0] v;
    for (int n = 0; n < max_instr && !mhalt; n++) begin
      imem_valid = 1'b0;
      check("fetch_req", 32'(imem_req), 32'd1);
      check("fetch_halted", 32'(halted), 32'd0);
      check("fetch_addr", 32'(imem_addr), 32'(mpc));
      check("pc_o", 32'(pc_o), 32'(mpc));
      check("retired", retired_count, mret);
      check("latency", 32'(cycles), 32'(exp_cyc));
      r = $urandom_range(0, 15);
      read_dbg(r, v);
      check("dbg", v, 32'(mreg[r]));
      w = $urandom_range(wmin, wmax);
      for (int i = 0; i < w; i++) begin
        imem_valid = 1'b0;
        imem_rdata = 16'($urandom);
        step();
        check("wait_req", 32'(imem_req), 32'd1);
        check("wait_addr", 32'(imem_addr), 32'(mpc));
      end
      ins        = prog[mpc];
      imem_valid = 1'b1;
      imem_rdata = ins;
      step();
      model_exec(ins);
      exp_cyc += w + 4;
      if (mhalt) begin
        drive_junk();
        step();
        check("halt_flag", 32'(halted), 32'd1);
        check("halt_req", 32'(imem_req), 32'd0);
        check("halt_retired", retired_count, mret);
        check("halt_pc", 32'(pc_o), 32'(mpc));
      end else begin
        repeat (3) begin
          drive_junk();
          step();
        end
      end
    end
    imem_valid = 1'b0;
  endtask

  task automatic check_frozen();
    repeat (4) begin
      drive_junk();
      step();
      check("frz_halted", 32'(halted), 32'd1);
      check("frz_req", 32'(imem_req), 32'd0);
      check("frz_retired", retired_count, mret);
      check("frz_pc", 32'(pc_o), 32'(mpc));
    end
    imem_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] v;
    n_checks   = 0;
    n_errors   = 0;
    rst        = 1'b1;
    imem_valid = 1'b0;
    imem_rdata = 16'h0000;
    dbg_sel    = 4'd0;

    // Zero-wait ALU sequence.
    clear_prog();
    prog[0] = 16'h6150;  // ADDI R1,R0,5
    prog[1] = 16'h6230;  // ADDI R2,R0,3
    prog[2] = 16'h1312;  // SUB  R3,R1,R2
    prog[3] = 16'h5421;  // SLT  R4,R2,R1
    do_reset();
    run_prog(4, 0, 0);
    check("t1_cycles", 32'(cycles), 32'd16);
    check("t1_retired", retired_count, 32'd4);
    read_dbg(3, v);
    check("t1_r3", v, 32'd2);
    read_dbg(4, v);
    check("t1_r4", v, 32'd1);

    // Three wait states per fetch.
    do_reset();
    run_prog(4, 3, 3);
    check("t2_cycles", 32'(cycles), 32'd28);

    // BEQ taken: PC 10 with offset -2 lands on 9.
    clear_prog();
    prog[0]  = 16'h6170;  // R1=7
    prog[1]  = 16'h6270;  // R2=7
    prog[2]  = 16'hC00A;  // JMP 10
    prog[10] = 16'h91E2;  // BEQ R1,R2,-2
    prog[9]  = 16'hF000;
    prog[11] = 16'hF000;
    do_reset();
    run_prog(10, 0, 2);
    check("t3_pc", 32'(pc_o), 32'd9);
    check("t3_halted", 32'(halted), 32'd1);

    // BEQ not taken falls through to 11.
    prog[1] = 16'h6260;  // R2=6
    do_reset();
    run_prog(10, 0, 2);
    check("t4_pc", 32'(pc_o), 32'd11);

    // JMP, PC wrap at 0xFFF, write to R0 dropped, HALT freeze.
    clear_prog();
    prog[0]     = 16'h6515;  // ADDI R5,R5,1
    prog[1]     = 16'h6620;  // ADDI R6,R0,2
    prog[2]     = 16'h9516;  // BEQ  R5,R6,+1
    prog[3]     = 16'hC123;  // JMP  0x123
    prog[4]     = 16'hF000;  // HALT
    prog[12'h123] = 16'h6090;  // ADDI R0,R0,9
    prog[12'h124] = 16'hCFFF;  // JMP  0xFFF
    prog[12'hFFF] = 16'hA000;  // NOP, wraps to 0
    do_reset();
    run_prog(20, 0, 1);
    check("t5_pc", 32'(pc_o), 32'd4);
    check("t5_retired", retired_count, 32'd11);
    read_dbg(0, v);
    check("t5_r0", v, 32'd0);
    read_dbg(5, v);
    check("t5_r5", v, 32'd2);
    check_frozen();

    // Reset asserted during EXEC takes effect immediately, no writeback.
    clear_prog();
    prog[0] = 16'h6150;  // R1=5
    prog[1] = 16'h6270;  // R2=7
    do_reset();
    run_prog(1, 0, 0);
    check("t6_pre_pc", 32'(pc_o), 32'd1);
    imem_valid = 1'b1;
    imem_rdata = prog[1];
    step();
    imem_valid = 1'b0;
    step();
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_pc", 32'(pc_o), 32'd0);
    check("t6_async_retired", retired_count, 32'd0);
    check("t6_async_halted", 32'(halted), 32'd0);
    check("t6_async_req", 32'(imem_req), 32'd1);
    do_reset();
    repeat (3) step();
    read_dbg(2, v);
    check("t6_r2", v, 32'd0);
    read_dbg(1, v);
    check("t6_r1", v, 32'd0);

    // MUL (or NOP when the multiplier is not built): 300*300.
    clear_prog();
    prog[0] = 16'h61F0;  // R1=15
    prog[1] = 16'h7141;  // R1=R1<<4 (240)
    prog[2] = 16'h61F1;  // 255
    prog[3] = 16'h61F1;  // 270
    prog[4] = 16'h61F1;  // 285
    prog[5] = 16'h61F1;  // 300
    prog[6] = 16'h6201;  // R2=R1
    prog[7] = 16'hB312;  // MUL R3,R1,R2
    prog[8] = 16'hF000;
    do_reset();
    run_prog(20, 0, 1);
    read_dbg(1, v);
    check("t7_r1", v, 32'd300);
    read_dbg(3, v);
`ifdef PROC_MUL_EN
    check("t7_r3", v, 32'h5F90);
`else
    check("t7_r3", v, 32'h0000);
`endif
    check("t7_retired", retired_count, 32'd9);

    // Random programs with random wait states.
    for (int s = 0; s < 6; s++) begin
      foreach (prog[i]) begin
        logic [15:0] x;
        x = 16'($urandom);
        if (x[15:12] == 4'hF && $urandom_range(0, 3) != 0) x[15:12] = 4'hA;
        prog[i] = x;
      end
      do_reset();
      run_prog(150, 0, 3);
      if (mhalt) check_frozen();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/processador_param.md
# processador_param

Parametrised multicycle successor of the single-cycle 16-bit core. It fetches 16-bit instructions over a variable-latency request/valid instruction-memory handshake and sequences each instruction through an explicit FETCH/DECODE/EXEC/WB state machine. Data width, PC width and register count are configurable. It adds conditional branches, shifts, HALT, a retired-instruction counter and a debug register read port.

## Interface
- DATA_W, 16: datapath and register width (≥8).
- ADDR_W, 12: PC and instruction-address width (≤12).
- NREG, 16: implemented registers (2..16). Indices ≥NREG read 0; writes to them are dropped.
- CLOCK_50  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- imem_req  out  1  fetch request; held high through the whole FETCH state.
- imem_addr  out  ADDR_W  fetch address, always equal to PC.
- imem_valid  in  1  imem_rdata is valid this cycle; ignored outside FETCH.
- imem_rdata  in  16  instruction word.
- pc_o  out  ADDR_W  current PC.
- halted  out  1  core is in HALT.
- retired_count  out  32  instructions completed, wraps modulo 2^32.
- dbg_sel  in  4  register index for the debug port.
- dbg_data  out  DATA_W  combinational read of R[dbg_sel].

## Operation
- Instruction fields: op=[15:12], rc=[11:8], ra=[7:4], rb=[3:0]. imm4=[7:4]. imm12=[11:0].
- R0 always reads 0; writes to R0 are discarded.
- R-type (write R[rc]):
  - 0 ADD: R[ra]+R[rb]
  - 1 SUB: R[ra]−R[rb]
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 SLT: signed R[ra]<R[rb] gives 1, else 0
- I-type (write R[rc]):
  - 6 ADDI: R[rb]+zext(imm4)
  - 7 SHL: R[rb]<<imm4
  - 8 SHR: logical R[rb]>>imm4
  - Shift amount ≥DATA_W gives 0.
- 9 BEQ: if R[rc]==R[rb], PC ← PC+1+sext(imm4); else PC ← PC+1.
- 12 JMP: PC ← imm12[ADDR_W-1:0].
- 15 HALT: enter HALT.
- 10, 13, 14 are NOPs. 11 is MUL or NOP (see Configuration).
- All arithmetic is modulo 2^DATA_W. PC arithmetic is modulo 2^ADDR_W (PC=2^ADDR_W−1 plus 1 wraps to 0).
- FSM states and transitions:
  - FETCH: imem_req=1. On imem_valid, latch IR and go to DECODE; otherwise stay.
  - DECODE: read R[ra], R[rb], R[rc] into operand registers. HALT opcode goes to HALT; all others go to EXEC.
  - EXEC: compute ALU result and next PC.
  - WB: write the result if the opcode writes a register, update PC, increment retired_count, return to FETCH.
  - HALT: terminal. imem_req=0, halted=1, PC frozen. Exited only by reset.
- HALT counts as retired: retired_count increments once on entry to HALT.

## Timing
- Reset values: all registers 0, PC=0, state=FETCH, imem_req=1 after release, halted=0, retired_count=0. The state and the outputs derived from it switch asynchronously the moment reset asserts.
- imem_valid may arrive in the first FETCH cycle, giving zero wait states.
- Instruction latency: 4 cycles plus wait cycles. FETCH (≥1), DECODE, EXEC, WB.
- A register written in WB is visible to the next instruction's DECODE.
- dbg_data shows the new value from the cycle after WB.
- imem_addr is stable for the whole of FETCH and changes only in WB.
- Reset mid-fetch abandons the fetch. A late imem_valid after reset release is treated as the response to the new fetch at PC=0; the memory must drop it.
- imem_valid asserted in DECODE/EXEC/WB/HALT has no effect.

## Configuration
- PROC_MUL_EN defined: opcode 11 is MUL, R[rc] ← low DATA_W bits of R[ra]*R[rb] (unsigned). Timing is the same 4-cycle flow, with a single-cycle multiplier in EXEC.
- PROC_MUL_EN undefined: opcode 11 is a NOP. No multiplier is synthesised. retired_count still increments.

## Test plan
- Zero-wait ALU sequence: ADDI R1,R0,5; ADDI R2,R0,3; SUB R3,R1,R2; SLT R4,R2,R1 → R3=2, R4=1, retired_count=4 at cycle 16.
- Wait states: imem_valid delayed 3 cycles per fetch → each instruction takes 7 cycles; imem_addr is constant while imem_req is high.
- Branch: R1=R2=7, BEQ R1,R2,imm4=0xE at PC=10 → next fetch address 9. With R2=6 → next fetch address 11.
- Wrap and JMP: ADDR_W=4, NOP at PC=15 → next fetch address 0. JMP 0x123 → PC=3.
- Writes to R0 dropped: ADDI R0,R0,9 → dbg_sel=0 reads 0. Then HALT → halted=1, imem_req=0, retired_count frozen.
- Reset mid-operation: assert reset during EXEC → outputs return to reset values immediately, with no writeback. With PROC_MUL_EN defined, R1=300, R2=300, MUL R3,R1,R2 → R3=0x5F90 (DATA_W=16).
